// File: rtl/demux4_pkg.sv
// Shared constants for the 1-to-4 lane distributor.
package demux4_pkg;
  localparam int WIDTH = 6;
  localparam int NCH   = 4;
  localparam int SEL_W = 2;
endpackage

// File: rtl/demux4_slot.sv
// One output lane: holding register plus valid flag, consumed by ack.
module demux4_slot
  import demux4_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             ack,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             valid
);

  // A load wins over an ack; a same-edge ack only retires the old word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q     <= '0;
      valid <= 1'b0;
    end else if (load) begin
      q     <= d;
      valid <= 1'b1;
    end else if (ack && valid) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux4_dist.sv
// Addressed / round-robin 1-to-4 distributor with per-lane holding slots.
module demux4_dist
  import demux4_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0] in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             rr_mode,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [NCH-1:0]   out_valid,
  input  logic [NCH-1:0]   out_ack,
  output logic [SEL_W-1:0] rr_ptr
);

  logic [SEL_W-1:0] tgt;
  logic             accept;
  logic [NCH-1:0]   load;
  logic [WIDTH-1:0] lane_q [NCH];

  assign tgt = rr_mode ? rr_ptr : in_sel;

  // An ack on the target lane frees it this cycle, allowing pass-through.
  assign in_ready = ~out_valid[tgt] | out_ack[tgt];
  assign accept   = in_valid & in_ready;

  always_comb begin
    load = '0;
    if (accept) load[tgt] = 1'b1;
  end

  for (genvar i = 0; i < NCH; i++) begin : g_slot
    demux4_slot u_slot (
      .clk   (clk),
      .reset (reset),
      .load  (load[i]),
      .ack   (out_ack[i]),
      .d     (in_data),
      .q     (lane_q[i]),
      .valid (out_valid[i])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (accept && rr_mode) begin
      rr_ptr <= rr_ptr + 2'd1;
    end
  end

  assign out0 = lane_q[0];
  assign out1 = lane_q[1];
  assign out2 = lane_q[2];
  assign out3 = lane_q[3];

endmodule

// File: tb/tb_demux4_dist.sv
// Bench for demux4_dist: array-based lane model checked every falling edge,
// plus directed scenarios with literal expectations.
module tb_demux4_dist;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] in_data;
  logic [1:0] in_sel;
  logic       in_valid;
  logic       in_ready;
  logic       rr_mode;
  logic [5:0] out0, out1, out2, out3;
  logic [3:0] out_valid;
  logic [3:0] out_ack;
  logic [1:0] rr_ptr;

  int tests = 0;
  int fails = 0;

  int m_data  [4] = '{0, 0, 0, 0};
  bit m_valid [4] = '{0, 0, 0, 0};
  int m_ptr = 0;

  demux4_dist dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rr_mode   (rr_mode),
    .out0      (out0),
    .out1      (out1),
    .out2      (out2),
    .out3      (out3),
    .out_valid (out_valid),
    .out_ack   (out_ack),
    .rr_ptr    (rr_ptr)
  );

  always #5 clk = ~clk;

  function automatic int lane(int i);
    case (i)
      0: return int'(out0);
      1: return int'(out1);
      2: return int'(out2);
      default: return int'(out3);
    endcase
  endfunction

  function automatic int m_target();
    return rr_mode ? m_ptr : int'(in_sel);
  endfunction

  function automatic bit m_ready();
    int t = m_target();
    return !m_valid[t] || out_ack[t];
  endfunction

  function automatic int m_valid_vec();
    int v = 0;
    for (int i = 0; i < 4; i++) if (m_valid[i]) v += (1 << i);
    return v;
  endfunction

  task automatic chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a lane is a box holding one word; acks empty boxes, an accepted
  // word fills the chosen box, the pointer counts round-robin accepts mod 4.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        m_data[i]  = 0;
        m_valid[i] = 0;
      end
      m_ptr = 0;
    end else begin
      int  t;
      bit  acc;
      t   = m_target();
      acc = in_valid && m_ready();
      for (int i = 0; i < 4; i++) begin
        if (acc && i == t) begin
          m_data[i]  = int'(in_data);
          m_valid[i] = 1;
        end else if (out_ack[i]) begin
          m_valid[i] = 0;
        end
      end
      if (acc && rr_mode) m_ptr = (m_ptr + 1) % 4;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) chk($sformatf("model_lane%0d", i), lane(i), m_data[i]);
      chk("model_out_valid", int'(out_valid), m_valid_vec());
      chk("model_rr_ptr", int'(rr_ptr), m_ptr);
      chk("model_in_ready", int'(in_ready), int'(m_ready()));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    automatic int vals [4] = '{'h11, 'h22, 'h33, 'h3F};
    in_data = '0; in_sel = '0; in_valid = 1'b0; rr_mode = 1'b0; out_ack = '0;
    #1 reset = 1'b1;
    #1;
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_rr_ptr", int'(rr_ptr), 0);
    chk("reset_in_ready", int'(in_ready), 1);
    chk("reset_out0", int'(out0), 0);
    repeat (2) cyc();
    reset = 1'b0;

    // addressed fill
    cyc();
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_sel = 2'(k); in_data = 6'(vals[k]);
      cyc();
      chk($sformatf("fill_lane%0d", k), lane(k), vals[k]);
    end
    in_valid = 1'b0;
    #1;
    chk("fill_out_valid", int'(out_valid), 'hF);
    chk("fill_out3", int'(out3), 'h3F);
    for (int k = 0; k < 4; k++) begin
      in_sel = 2'(k);
      #1 chk($sformatf("full_ready_sel%0d", k), int'(in_ready), 0);
    end
    out_ack = 4'hF;
    cyc();
    out_ack = 4'h0;

    // backpressure and pass-through on lane 2
    in_valid = 1'b1; in_sel = 2'd2; in_data = 6'h05;
    cyc();
    in_data = 6'h2A;
    #1 chk("bp_ready_noack", int'(in_ready), 0);
    cyc(); cyc();
    chk("bp_out2_held", int'(out2), 'h05);
    out_ack = 4'b0100;
    #1 chk("bp_ready_ack", int'(in_ready), 1);
    cyc();
    out_ack = 4'h0; in_valid = 1'b0;
    #1;
    chk("bp_out2_new", int'(out2), 'h2A);
    chk("bp_valid2", int'(out_valid[2]), 1);
    out_ack = 4'hF;
    cyc();

    // round-robin wrap with acks tied high
    rr_mode = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      in_valid = 1'b1; in_data = 6'(k);
      cyc();
      chk($sformatf("rr_word%0d", k), lane((k - 1) % 4), k);
    end
    chk("rr_ptr_after6", int'(rr_ptr), 2);
    in_valid = 1'b0;
    cyc(); cyc();
    chk("rr_ptr_gap", int'(rr_ptr), 2);
    out_ack = 4'h0;

    // stall must not advance the pointer
    in_valid = 1'b1; in_data = 6'h07; cyc();
    in_data = 6'h08; cyc();
    rr_mode = 1'b0; in_sel = 2'd0; in_data = 6'h09; cyc();
    chk("stall_ptr_start", int'(rr_ptr), 0);
    rr_mode = 1'b1; in_data = 6'h10;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("stall_rr_ptr", int'(rr_ptr), 0);
      chk("stall_out0", int'(out0), 'h09);
    end
    out_ack = 4'b0001;
    cyc();
    out_ack = 4'h0; in_valid = 1'b0;
    #1;
    chk("stall_out0_new", int'(out0), 'h10);
    chk("stall_rr_ptr_adv", int'(rr_ptr), 1);

    // stray and multi ack
    out_ack = 4'b1000;
    cyc();
    chk("multi_pre_valid", int'(out_valid), 'b0101);
    out_ack = 4'hF;
    cyc();
    out_ack = 4'h0;
    chk("multi_valid", int'(out_valid), 0);
    chk("multi_out0", int'(out0), 'h10);
    chk("multi_out1", int'(out1), 'h06);
    chk("multi_out2", int'(out2), 'h07);
    chk("multi_out3", int'(out3), 'h08);
    chk("multi_rr_ptr", int'(rr_ptr), 1);

    // async reset mid-stream
    in_valid = 1'b1; in_data = 6'h21; cyc();
    in_data = 6'h22; cyc();
    rr_mode = 1'b0; in_sel = 2'd0; in_data = 6'h23; cyc();
    in_sel = 2'd3; in_data = 6'h24; cyc();
    in_valid = 1'b0;
    chk("prereset_valid", int'(out_valid), 'hF);
    chk("prereset_rr_ptr", int'(rr_ptr), 3);
    in_valid = 1'b1; in_sel = 2'd1; in_data = 6'h3C;
    #2 reset = 1'b1;
    #1;
    chk("areset_valid", int'(out_valid), 0);
    chk("areset_rr_ptr", int'(rr_ptr), 0);
    chk("areset_out1", int'(out1), 0);
    chk("areset_out3", int'(out3), 0);
    cyc();
    #3 reset = 1'b0; in_valid = 1'b0;
    #1 chk("post_reset_ready", int'(in_ready), 1);
    cyc(); cyc();
    chk("post_reset_valid", int'(out_valid), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
